// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU: FSM controller, PC, IR, register file, ALU and datapath latches.
// Instruction and data memories are external, reached through req/ack handshakes.
module multicycle_cpu #(
    parameter  int DATA_W  = 8,
    parameter  int PC_W    = 12,
    parameter  int RAW     = 3,
    localparam int INSTR_W = 4 + 3*RAW + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic               retire,
    output logic               halted,
    output logic [PC_W-1:0]    pc_dbg
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3,
                           OP_ADDI = 4'h4, OP_SUBI = 4'h5, OP_LD = 4'h6, OP_ST = 4'h7,
                           OP_JMP = 4'h8, OP_BZ = 4'h9, OP_BNZ = 4'hA, OP_HALT = 4'hF;

    state_t             state, state_nx;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  a, b, aluout, mdr;
    logic [DATA_W-1:0]  rf [2**RAW];
    logic               retire_q, done;

    logic [3:0]         op;
    logic [RAW-1:0]     rd, rs1, rs2;
    logic [DATA_W-1:0]  imm, alu_res;
    logic [PC_W-1:0]    imm_pc, br_target;
    logic               is_alu, is_mem, is_ctrl, taken;

    assign op  = ir[INSTR_W-1 -: 4];
    assign rd  = ir[INSTR_W-5 -: RAW];
    assign rs1 = ir[INSTR_W-5-RAW -: RAW];
    assign rs2 = ir[INSTR_W-5-2*RAW -: RAW];
    assign imm = ir[DATA_W-1:0];

    // Branch offset: sign-extend when PC is wider, otherwise keep the low PC_W bits.
    if (PC_W > DATA_W) begin : g_sext
        assign imm_pc = {{(PC_W-DATA_W){imm[DATA_W-1]}}, imm};
    end else begin : g_trunc
        assign imm_pc = imm[PC_W-1:0];
    end

    assign is_alu  = (op <= OP_SUBI);
    assign is_mem  = (op == OP_LD) || (op == OP_ST);
    assign is_ctrl = (op == OP_JMP) || (op == OP_BZ) || (op == OP_BNZ);

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SUBI: alu_res = a - imm;
            default: alu_res = a + imm;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_BZ:   taken = (a == '0);
            OP_BNZ:  taken = (a != '0);
            default: taken = 1'b0;
        endcase
    end

    // PC already points past the branch, so pc + sext(imm) is pc_branch + 1 + sext(imm).
    assign br_target = (op == OP_JMP) ? ir[PC_W-1:0] : pc + imm_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH:  if (imem_ack) state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                if (op == OP_HALT)  state_nx = S_HALT;
                else if (is_alu)    state_nx = S_WB;
                else if (is_mem)    state_nx = S_MEM;
                else begin
                    state_nx = S_FETCH;
                    done     = 1'b1;
                end
            end
            S_MEM: if (dmem_ack) begin
                if (op == OP_LD) state_nx = S_WB;
                else begin
                    state_nx = S_FETCH;
                    done     = 1'b1;
                end
            end
            S_WB: begin
                state_nx = S_FETCH;
                done     = 1'b1;
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
    end

    // retire is registered so it depends on flops only; it pulses the cycle after completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            aluout   <= '0;
            mdr      <= '0;
            retire_q <= 1'b0;
            for (int i = 0; i < 2**RAW; i++) rf[i] <= '0;
        end else begin
            retire_q <= done;
            case (state)
                S_FETCH: if (imem_ack) begin
                    ir <= imem_rdata;
                    pc <= pc + 1'b1;
                end
                S_DECODE: begin
                    a <= rf[rs1];
                    b <= rf[rs2];
                end
                S_EXEC: begin
                    aluout <= alu_res;
                    if (is_ctrl && taken) pc <= br_target;
                end
                S_MEM: if (dmem_ack && op == OP_LD) mdr <= dmem_rdata;
                S_WB:  if (rd != '0) rf[rd] <= (op == OP_LD) ? mdr : aluout;
                default: ;
            endcase
        end
    end

    assign imem_req   = (state == S_FETCH);
    assign imem_addr  = pc;
    assign dmem_req   = (state == S_MEM);
    assign dmem_we    = (state == S_MEM) && (op == OP_ST);
    assign dmem_addr  = aluout;
    assign dmem_wdata = b;
    assign retire     = retire_q;
    assign halted     = (state == S_HALT);
    assign pc_dbg     = pc;
endmodule
